or_result_fifo: RTL

- Downstream buffer stage for the 8-bit OR unit; captures result Y on a push strobe and holds it for readout on a pop strobe.
- Lets the pin-level bench sample OR results at its own pace: first-word-fall-through FIFO with full/empty/count and sticky error flags.
- Sits between the OR unit output and uo_out inside the top-level wrapper.

---
 rtl/or_result_fifo.sv | 124 ++++++++++++
 1 files changed

// File: rtl/or_result_fifo.sv
// or_result_fifo: first-word-fall-through buffer for OR-unit results, with count,
// full/empty and sticky overflow/underflow flags. Define OR_FIFO_EDGE_SYNC_EN to edge-sync push/pop pins.
module or_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         y_in,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_push_req;
    logic             w_pop_req;
    logic             w_empty;
    logic             w_full;
    logic             w_push_acc;
    logic             w_pop_acc;
    logic             w_ovf_set;
    logic             w_unf_set;
    logic [CW-1:0]    w_count_next;

`ifdef OR_FIFO_EDGE_SYNC_EN
    // Two-flop synchronizer plus a rising-edge detector per strobe: one pin pulse, one operation.
    logic [1:0] r_push_sync;
    logic [1:0] r_pop_sync;
    logic       r_push_last;
    logic       r_pop_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_push_sync <= '0;
            r_pop_sync  <= '0;
            r_push_last <= 1'b0;
            r_pop_last  <= 1'b0;
        end else begin
            r_push_sync <= {r_push_sync[0], push};
            r_pop_sync  <= {r_pop_sync[0], pop};
            r_push_last <= r_push_sync[1];
            r_pop_last  <= r_pop_sync[1];
        end
    end

    assign w_push_req = r_push_sync[1] & ~r_push_last;
    assign w_pop_req  = r_pop_sync[1] & ~r_pop_last;
`else
    assign w_push_req = push;
    assign w_pop_req  = pop;
`endif

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_COUNT);

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_pop_acc  = w_pop_req & ~w_empty & ~clear;
    assign w_push_acc = w_push_req & (~w_full | w_pop_acc) & ~clear;
    assign w_ovf_set  = w_push_req & w_full & ~w_pop_acc;
    assign w_unf_set  = w_pop_req & w_empty;

    // NOTE: always_comb gives every output a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_count_next = r_count;
        case ({w_push_acc, w_pop_acc})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count     <= w_count_next;
            r_overflow  <= r_overflow | w_ovf_set;
            r_underflow <= r_underflow | w_unf_set;
        end
    end

    // NOTE: storage has no reset; count==0 already marks every entry invalid.
    always_ff @(posedge clk) begin
        if (w_push_acc) r_mem[r_wr_ptr] <= y_in;
    end

    assign rd_data   = w_empty ? '0 : r_mem[r_rd_ptr];
    assign empty     = w_empty;
    assign full      = w_full;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
